// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and checksum helper for the framed UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER    = 8'hAA;
    localparam logic [7:0] DEFAULT_TRAILER   = 8'hBB;
    localparam int         UART_FRAME_BITS   = 10;
    localparam int         MAX_PAYLOAD_BYTES = 32;
    localparam int         MAX_PAYLOAD_BITS  = 8 * MAX_PAYLOAD_BYTES;

    // XOR of the low n bytes of a zero-extended payload.
    function automatic logic [7:0] xor_bytes(input logic [MAX_PAYLOAD_BITS-1:0] payload, input int n);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            if (i < n) begin
                acc = acc ^ payload[8*i +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 serialiser for one byte; owns the bit divider and bit counter
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 52
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [3:0]     BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic [DW-1:0] div;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          active;

    // Combinational so the top can load the next byte on the very edge the stop bit ends.
    assign byte_done = active && (div == DIV_LAST) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            active  <= 1'b0;
        end else if (load) begin
            tx      <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= data;
            active  <= 1'b1;
        end else if (active) begin
            if (div == DIV_LAST) begin
                div <= '0;
                if (bit_cnt == BIT_LAST) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - framed UART transmitter: header, payload, checksum, trailer, then idle gap
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int         CLK_DIV       = 52,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] HEADER        = DEFAULT_HEADER,
    parameter logic [7:0] TRAILER       = DEFAULT_TRAILER,
    parameter int         CHECKSUM_EN   = 1,
    parameter int         GAP_CYCLES    = 4_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic                       uart_tx
);

    localparam int NB = PAYLOAD_BYTES + 2 + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int BW = $clog2(NB);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_frame_tx: CLK_DIV must be >= 2");
    end
    if (PAYLOAD_BYTES < 1) begin : g_bad_payload
        $error("uart_frame_tx: PAYLOAD_BYTES must be >= 1");
    end
    if (PAYLOAD_BYTES > MAX_PAYLOAD_BYTES) begin : g_big_payload
        $error("uart_frame_tx: PAYLOAD_BYTES exceeds checksum helper width");
    end

    state_t                     state;
    logic [8*PAYLOAD_BYTES-1:0] payload_q;
    logic [7:0]                 csum_q;
    logic [BW-1:0]              byte_idx;
    logic [BW-1:0]              next_idx;
    logic [GW-1:0]              gap_cnt;
    logic [7:0]                 next_data;
    logic                       accept;
    logic                       last_byte;
    logic                       load;
    logic                       byte_done;

    // The final gap edge doubles as an accept edge so a held start leaves exactly GAP_CYCLES idle cycles.
    assign accept    = start && ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));
    assign last_byte = (byte_idx == BYTE_LAST);
    assign load      = accept || ((state == SEND) && byte_done && !last_byte);

    always_comb begin
        next_idx  = byte_idx + 1'b1;
        next_data = TRAILER;
        if (accept) begin
            next_data = HEADER;
        end else begin
            for (int i = 1; i <= PAYLOAD_BYTES; i++) begin
                if (int'(next_idx) == i) begin
                    next_data = payload_q[8*(PAYLOAD_BYTES-i) +: 8];
                end
            end
            if ((CHECKSUM_EN != 0) && (int'(next_idx) == PAYLOAD_BYTES + 1)) begin
                next_data = csum_q;
            end
        end
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (next_data),
        .tx        (uart_tx),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
            payload_q <= '0;
            csum_q    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= SEND;
                payload_q <= payload;
                csum_q    <= xor_bytes(MAX_PAYLOAD_BITS'(payload), PAYLOAD_BYTES);
                byte_idx  <= '0;
                gap_cnt   <= '0;
                busy      <= 1'b1;
                ready     <= 1'b0;
            end else begin
                case (state)
                    SEND: begin
                        if (byte_done) begin
                            if (last_byte) begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                byte_idx <= '0;
                                gap_cnt  <= '0;
                                if (GAP_CYCLES == 0) begin
                                    state <= IDLE;
                                    ready <= 1'b1;
                                end else begin
                                    state <= GAP;
                                end
                            end else begin
                                byte_idx <= next_idx;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= IDLE;
                            ready   <= 1'b1;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - self-checking bench for uart_frame_tx across four parameter sets
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start_v = '0;
    logic [31:0] pl_bus = '0;
    logic [3:0]  tx_v, ready_v, busy_v, done_v;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    // 0: defaults, 1: 2-byte/no-checksum/no-gap, 2: 10-cycle gap, 3: 3-byte with checksum
    uart_frame_tx u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .payload(pl_bus),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .uart_tx(tx_v[0])
    );
    uart_frame_tx #(.CLK_DIV(4), .PAYLOAD_BYTES(2), .CHECKSUM_EN(0), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .payload(pl_bus[15:0]),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .uart_tx(tx_v[1])
    );
    uart_frame_tx #(.CLK_DIV(4), .GAP_CYCLES(10)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .payload(pl_bus),
        .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .uart_tx(tx_v[2])
    );
    uart_frame_tx #(.CLK_DIV(4), .PAYLOAD_BYTES(3), .CHECKSUM_EN(1), .GAP_CYCLES(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .payload(pl_bus[23:0]),
        .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .uart_tx(tx_v[3])
    );

    typedef struct {
        int          id;
        int          div;
        int          pb;
        bit          cs;
        logic [7:0]  csum;
        logic [31:0] pl;
        bit          rdy_end;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_and_check(input int id);
        @(negedge clk);
        rst_n = 1'b0;
        start_v = '0;
        @(negedge clk);
        check("reset_state", {tx_v[id], ready_v[id], busy_v[id], done_v[id]}, 4'b1100);
        rst_n = 1'b1;
    endtask

    // Sample t is taken on the negedge following edge k+t, where k is the accepting edge.
    task automatic run_frame(input int id, input int div, input int pb, input bit cs,
                             input logic [7:0] csum, input logic [31:0] pl,
                             input bit prestarted, input bit hold, input bit poke,
                             input bit rdy_end);
        logic [7:0] eb[0:7];
        logic [9:0] rx;
        int nb, len, bidx, bpos;
        int line_err, busy_err, done_err;
        logic exp_bit;
        nb = pb + 2 + (cs ? 1 : 0);
        len = 10 * nb * div;
        eb[0] = 8'hAA;
        for (int i = 0; i < pb; i++) eb[1+i] = pl[8*(pb-1-i) +: 8];
        if (cs) eb[pb+1] = csum;
        eb[nb-1] = 8'hBB;
        for (int i = 0; i < nb; i++) sb_q.push_back(eb[i]);
        if (!prestarted) begin
            start_v[id] = 1'b1;
            pl_bus = pl;
        end
        line_err = 0; busy_err = 0; done_err = 0; rx = '0;
        for (int t = 0; t <= len; t++) begin
            @(negedge clk);
            if (t == 0 && !hold) start_v[id] = 1'b0;
            if (poke) begin
                if (t == 100 || t == 2000) begin
                    start_v[id] = 1'b1;
                    pl_bus = 32'hFFFFFFFF;
                end else if (t == 101 || t == 2001) begin
                    start_v[id] = 1'b0;
                end
            end
            if (t < len) begin
                bidx = t / (10 * div);
                bpos = (t / div) % 10;
                if (bpos == 0) exp_bit = 1'b0;
                else if (bpos == 9) exp_bit = 1'b1;
                else exp_bit = eb[bidx][bpos-1];
            end else begin
                exp_bit = 1'b1;
            end
            if (tx_v[id] !== exp_bit) line_err++;
            if (busy_v[id] !== (t < len)) busy_err++;
            if (done_v[id] !== (t == len)) done_err++;
            if (t < len && (t % div) == div / 2) begin
                rx[bpos] = tx_v[id];
                if (bpos == 9) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL sb_pop: queue empty, got byte %0h", rx[8:1]);
                    end else begin
                        check("byte", rx[8:1], sb_q.pop_front());
                    end
                end
            end
        end
        check("line_waveform_errs", line_err, 0);
        check("busy_errs", busy_err, 0);
        check("done_errs", done_err, 0);
        check("ready_at_done", ready_v[id], rdy_end);
    endtask

    initial begin
        int gerr, derr;
        vecs[0] = '{id: 0, div: 52, pb: 4, cs: 1'b1, csum: 8'h01, pl: 32'h00000100, rdy_end: 1'b0};
        vecs[1] = '{id: 1, div: 4,  pb: 2, cs: 1'b0, csum: 8'h00, pl: 32'h00001234, rdy_end: 1'b1};
        vecs[2] = '{id: 3, div: 4,  pb: 3, cs: 1'b1, csum: 8'h96, pl: 32'h00A53C0F, rdy_end: 1'b1};
        vecs[3] = '{id: 2, div: 4,  pb: 4, cs: 1'b1, csum: 8'h22, pl: 32'hDEADBEEF, rdy_end: 1'b0};
        vecs[4] = '{id: 0, div: 52, pb: 4, cs: 1'b1, csum: 8'h00, pl: 32'h80FF7E01, rdy_end: 1'b0};

        for (int v = 0; v < 5; v++) begin
            reset_and_check(vecs[v].id);
            run_frame(vecs[v].id, vecs[v].div, vecs[v].pb, vecs[v].cs, vecs[v].csum,
                      vecs[v].pl, 1'b0, 1'b0, 1'b0, vecs[v].rdy_end);
        end

        // Back-to-back frames with no gap: second start lands on the edge after done.
        reset_and_check(1);
        run_frame(1, 4, 2, 1'b0, 8'h00, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(1, 4, 2, 1'b0, 8'h00, 32'h00005AC3, 1'b0, 1'b0, 1'b0, 1'b1);

        // Starts and payload changes during a frame must be ignored; exactly one done.
        reset_and_check(0);
        run_frame(0, 52, 4, 1'b1, 8'h01, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0);
        derr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b0 || tx_v[0] !== 1'b1) derr++;
        end
        check("post_frame_quiet", derr, 0);

        // Held start with a 10-cycle gap: 10 idle-high cycles, then the next start bit.
        reset_and_check(2);
        run_frame(2, 4, 4, 1'b1, 8'h22, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        gerr = 0;
        for (int g = 1; g <= 9; g++) begin
            @(negedge clk);
            if (tx_v[2] !== 1'b1 || ready_v[2] !== 1'b0 || busy_v[2] !== 1'b0) gerr++;
        end
        check("gap_idle_errs", gerr, 0);
        run_frame(2, 4, 4, 1'b1, 8'h22, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        start_v[2] = 1'b0;

        // Reset mid data bit of the second byte, then a clean frame.
        reset_and_check(0);
        start_v[0] = 1'b1;
        pl_bus = 32'h12345678;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int t = 1; t <= 754; t++) @(negedge clk);
        check("mid_frame_busy", busy_v[0], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", {tx_v[0], ready_v[0], busy_v[0], done_v[0]}, 4'b1100);
        rst_n = 1'b1;
        run_frame(0, 52, 4, 1'b1, 8'h76, 32'hCAFE0042, 1'b0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_left", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised framed UART transmitter for sending measurement results to the host link. On a start handshake it latches a multi-byte payload and serialises this frame, 8N1: header byte, PAYLOAD_BYTES payload bytes (most-significant byte first), an optional XOR checksum byte, then a trailer byte. After each frame it enforces a programmable inter-frame idle gap. It sits between the measurement core (frequency/phase registers) and the board TX pin.

Parameters:
CLK_DIV, 52, clock cycles per UART bit; legal range >= 2.
PAYLOAD_BYTES, 4, number of payload bytes per frame; legal range >= 1.
HEADER, 8'hAA, first byte of every frame.
TRAILER, 8'hBB, last byte of every frame.
CHECKSUM_EN, 1, when 1 an XOR-of-payload byte is inserted before TRAILER.
GAP_CYCLES, 4_000_000, idle cycles after a frame during which ready=0; 0 is legal.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset; synchronous, active-low.
start  in  1  frame request; accepted only when ready=1.
payload  in  8*PAYLOAD_BYTES  frame data; sampled on the accepting edge.
ready  out  1  1 = a start will be accepted.
busy  out  1  1 = frame being shifted out (SEND state).
done  out  1  single-cycle pulse when the final stop bit completes.
uart_tx  out  1  serial line; idle high.

Behaviour:
- Reset (rst_n=0 at an edge): uart_tx=1, ready=1, busy=0, done=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately; no partial byte is completed.
- All outputs are registered.
- States: IDLE -> SEND -> GAP -> IDLE.
  - If GAP_CYCLES=0, SEND -> IDLE directly.
- IDLE: ready=1, uart_tx=1.
  - The edge k is the clock edge at which start=1 is sampled.
  - At edge k: latch payload, compute checksum (XOR of all payload bytes), clear the bit divider and bit/byte counters, drive uart_tx=0 (start bit), busy=1, ready=0.
- SEND:
  - Every bit lasts exactly CLK_DIV cycles. The divider restarts per frame, so the first bit is full width.
  - Byte format: start bit 0, data bits 0..7 LSB first, stop bit 1.
  - Byte order: HEADER, payload[8N-1:8N-8] ... payload[7:0], [checksum], TRAILER.
  - NB = PAYLOAD_BYTES+2+CHECKSUM_EN bytes; frame length = 10*NB*CLK_DIV cycles from edge k.
  - No extra idle between bytes.
- End of the last stop bit (edge k+10*NB*CLK_DIV): done=1 for one cycle and busy=0.
  - If GAP_CYCLES>0: enter GAP with ready=0.
  - If GAP_CYCLES=0: enter IDLE with ready=1 on the same edge.
- GAP: uart_tx=1. Count GAP_CYCLES cycles, then ready=1 (IDLE).
- start while ready=0 is ignored. There is no queue, and no state or latched-data change.
- A payload change during SEND has no effect on the current frame.
- Counter widths:
  - divider: $clog2(CLK_DIV).
  - bit counter: 4 bits (0..9).
  - byte index: $clog2(NB).
  - gap counter: $clog2(GAP_CYCLES+1), minimum 1 bit.
- Elaboration must fail (assert/$error) if CLK_DIV<2 or PAYLOAD_BYTES<1.

Decomposition:
- Shared package uart_pkg: the state enum (IDLE/SEND/GAP), default HEADER/TRAILER constants, the 8N1 frame-length constant (10 bits), and a function xor_bytes(payload, n) for the checksum.
- One natural sub-module, uart_byte_tx:
  - Owns the divider and bit counter and serialises one byte.
  - Interface: load/data in; tx/byte_done out.
- The top handles the byte sequencing, latching, checksum and gap.

Test Plan:
- Defaults, payload=32'h00000100, start at edge k. Required:
  - Line decodes AA 00 00 01 00 01 BB.
  - Every bit is 52 cycles.
  - done pulses exactly at k+3640.
  - busy=1 over [k, k+3640).
- PAYLOAD_BYTES=2, CHECKSUM_EN=0, CLK_DIV=4, GAP_CYCLES=0, payload=16'h1234. Required:
  - Bytes AA 12 34 BB.
  - Frame is 160 cycles.
  - ready=1 in the done cycle.
  - A start on that next edge begins a new frame with no gap.
- Start pulsed at k+100 and k+2000 during a default frame, with payload changed to 32'hFFFFFFFF. Required:
  - Both pulses are ignored.
  - The frame is unchanged and exactly one done pulse occurs.
- GAP_CYCLES=10, CLK_DIV=4. Start held high continuously. Required:
  - Frames are separated by exactly 10 idle-high cycles.
  - ready=0 during the gap.
  - The next start bit appears on the edge the gap ends.
- rst_n=0 for one edge mid-data-bit of the second byte. Required:
  - uart_tx=1, ready=1, busy=0, done=0 after that edge.
  - The next start yields a complete, correct frame.
- PAYLOAD_BYTES=3, CHECKSUM_EN=1, payload=24'hA5_3C_0F. Required: checksum byte = 8'h96, and the frame is AA A5 3C 0F 96 BB.
